// File: rtl/shiftreg_ctrl_pkg.sv
// Shared types and helpers for the shiftreg sequencing controller.
// PAR state is only reachable when SHIFTREG_CTRL_PARITY_EN is defined.
package shiftreg_ctrl_pkg;

    localparam int unsigned SR_W_DEFAULT = 8;
    localparam int unsigned SR_MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        PAR   = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [SR_MAX_W-1:0] bit_reverse(input logic [SR_MAX_W-1:0] v,
                                                         input int unsigned w);
        logic [SR_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SR_MAX_W; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

    function automatic logic parity(input logic [SR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/shiftreg_ctrl_if.sv
// Producer-side word handshake plus sink-side serial stream of shiftreg_ctrl.
interface shiftreg_ctrl_if
    import shiftreg_ctrl_pkg::*;
#(
    parameter int unsigned W = SR_W_DEFAULT
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         ser_valid;
    logic         ser_bit;
    logic         ser_last;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_valid, ser_bit, ser_last
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_valid, ser_bit, ser_last
    );
endinterface

// File: rtl/shiftreg.sv
// Existing 8-bit (parameterisable) load/shift register driven by shiftreg_ctrl.
module shiftreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         in_bit,
    input  logic [W-1:0] w_data,
    input  logic         w_en,
    output logic         out_bit
);
    logic [W-1:0] reg_q;

    always_ff @(posedge clk) begin
        if (w_en) begin
            reg_q <= w_data;
        end else begin
            reg_q <= {reg_q[W-2:0], in_bit};
        end
    end

    assign out_bit = reg_q[W-1];
endmodule

// File: rtl/shiftreg_ctrl.sv
// Sequences words into an external shiftreg and frames its serial output.
// Optional trailing even-parity bit: define SHIFTREG_CTRL_PARITY_EN.
module shiftreg_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int unsigned W         = SR_W_DEFAULT,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic        FILL      = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    shiftreg_ctrl_if.slave   bus,
    output logic             sr_w_en,
    output logic [W-1:0]     sr_w_data,
    output logic             sr_in_bit,
    input  logic             sr_out_bit,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int unsigned    CW       = cnt_width(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        word_q, word_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [SR_MAX_W-1:0] word_ext;
    logic [W-1:0]        load_word;
    logic                frame_end;

    always_comb begin
        word_ext         = '0;
        word_ext[W-1:0]  = word_q;
    end

    assign load_word = LSB_FIRST ? W'(bit_reverse(word_ext, W)) : word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        frame_cnt_d   = frame_cnt_q;
        frame_end     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_bit   = 1'b0;
        bus.ser_last  = 1'b0;
        sr_w_en       = 1'b0;
        sr_w_data     = word_q;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_w_en   = 1'b1;
                sr_w_data = load_word;
                cnt_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                bus.ser_valid = 1'b1;
                bus.ser_bit   = sr_out_bit;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
`ifdef SHIFTREG_CTRL_PARITY_EN
                    state_d = PAR;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SHIFTREG_CTRL_PARITY_EN
            PAR: begin
                bus.ser_valid = 1'b1;
                bus.ser_bit   = parity(word_ext);
                frame_end     = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Final frame bit: flag last, count the frame and allow a back-to-back accept.
        if (frame_end) begin
            bus.ser_last = 1'b1;
            bus.in_ready = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            if (bus.in_valid) begin
                word_d  = bus.in_data;
                state_d = LOAD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign sr_in_bit = FILL;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Scoreboard bench: an MSB-first and an LSB-first controller, each with its own shiftreg,
// share one randomized producer; expected frames are queued per lane at accept time.
module tb_shiftreg_ctrl;
    localparam int W = 8;
`ifdef SHIFTREG_CTRL_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clk = ~clk;

    shiftreg_ctrl_if #(.W(W)) bus_m ();
    shiftreg_ctrl_if #(.W(W)) bus_l ();

    assign bus_m.in_valid = in_valid;
    assign bus_m.in_data  = in_data;
    assign bus_l.in_valid = in_valid;
    assign bus_l.in_data  = in_data;

    logic         sr_w_en_m, sr_in_bit_m, sr_out_bit_m, busy_m;
    logic [W-1:0] sr_w_data_m;
    logic [15:0]  frame_cnt_m;
    logic         sr_w_en_l, sr_in_bit_l, sr_out_bit_l, busy_l;
    logic [W-1:0] sr_w_data_l;
    logic [15:0]  frame_cnt_l;

    shiftreg_ctrl #(.W(W), .LSB_FIRST(1'b0), .FILL(1'b0), .CNT_W(16)) u_ctrl_m (
        .clk(clk), .rst(rst), .bus(bus_m),
        .sr_w_en(sr_w_en_m), .sr_w_data(sr_w_data_m), .sr_in_bit(sr_in_bit_m),
        .sr_out_bit(sr_out_bit_m), .busy(busy_m), .frame_cnt(frame_cnt_m)
    );
    shiftreg #(.W(W)) u_sr_m (
        .clk(clk), .in_bit(sr_in_bit_m), .w_data(sr_w_data_m), .w_en(sr_w_en_m),
        .out_bit(sr_out_bit_m)
    );

    shiftreg_ctrl #(.W(W), .LSB_FIRST(1'b1), .FILL(1'b1), .CNT_W(16)) u_ctrl_l (
        .clk(clk), .rst(rst), .bus(bus_l),
        .sr_w_en(sr_w_en_l), .sr_w_data(sr_w_data_l), .sr_in_bit(sr_in_bit_l),
        .sr_out_bit(sr_out_bit_l), .busy(busy_l), .frame_cnt(frame_cnt_l)
    );
    shiftreg #(.W(W)) u_sr_l (
        .clk(clk), .in_bit(sr_in_bit_l), .w_data(sr_w_data_l), .w_en(sr_w_en_l),
        .out_bit(sr_out_bit_l)
    );

    typedef struct {
        logic b;
        logic l;
        int   cyc;
    } exp_t;

    exp_t q[2][$];
    int   lasts[$];
    int   fc       = 0;
    int   last_cyc = -1;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    bit   chk_en   = 1'b0;
    bit   acc_flag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int lane, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s lane%0d cyc=%0d actual=%0d required=%0d", nm, lane, cyc, act, req);
        end
    endtask

    task automatic check_lane(input int j, input logic v, input logic b, input logic l);
        exp_t e;
        if (v) begin
            if (q[j].size() == 0) begin
                chk("unexpected_valid", j, 1, 0);
            end else begin
                e = q[j].pop_front();
                chk("bit_cycle", j, cyc, e.cyc);
                chk("ser_bit", j, int'(b), int'(e.b));
                chk("ser_last", j, int'(l), int'(e.l));
            end
        end else begin
            chk("ser_last_without_valid", j, int'(l), 0);
            if (q[j].size() != 0 && q[j][0].cyc <= cyc) begin
                chk("missing_valid", j, 0, 1);
                void'(q[j].pop_front());
            end
        end
    endtask

    task automatic push_frame(input logic [7:0] w, input int base);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.cyc = base + 2 + k;
            e.l   = (k == W - 1) && (FL == W);
            e.b   = w[W-1-k];
            q[0].push_back(e);
            e.b   = w[k];
            q[1].push_back(e);
        end
        if (FL > W) begin
            e.cyc = base + 2 + W;
            e.l   = 1'b1;
            e.b   = ^w;
            q[0].push_back(e);
            q[1].push_back(e);
        end
        last_cyc = base + 1 + FL;
        lasts.push_back(last_cyc);
    endtask

    // Monitor: compare outputs against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_lane(0, bus_m.ser_valid, bus_m.ser_bit, bus_m.ser_last);
            check_lane(1, bus_l.ser_valid, bus_l.ser_bit, bus_l.ser_last);
            chk("in_ready", 0, int'(bus_m.in_ready), int'(cyc >= last_cyc));
            chk("in_ready", 1, int'(bus_l.in_ready), int'(cyc >= last_cyc));
            chk("busy", 0, int'(busy_m), int'(cyc <= last_cyc));
            chk("busy", 1, int'(busy_l), int'(cyc <= last_cyc));
            chk("frame_cnt", 0, int'(frame_cnt_m), fc % 65536);
            chk("frame_cnt", 1, int'(frame_cnt_l), fc % 65536);
            chk("sr_in_bit", 0, int'(sr_in_bit_m), 0);
            chk("sr_in_bit", 1, int'(sr_in_bit_l), 1);

            if (rst) begin
                q[0].delete();
                q[1].delete();
                lasts.delete();
                fc       = 0;
                last_cyc = -1;
            end else begin
                if (lasts.size() != 0 && lasts[0] == cyc) begin
                    void'(lasts.pop_front());
                    fc++;
                end
                if (in_valid && bus_m.in_ready) begin
                    push_frame(in_data, cyc);
                    acc_flag = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] w);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (acc_flag) begin
                ok       = 1'b1;
                acc_flag = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout word=%0h actual=not_accepted required=accepted", w);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst    = 1'b0;
        idle(3);

        send(8'h55);
        idle(FL + 4);
        send(8'h01);
        idle(FL + 4);
        send(8'hA5);
        send(8'h3C);
        idle(FL + 4);
        send(8'h07);
        idle(3);
        send(8'h03);
        idle(FL + 4);

        // Reset during the 4th shift cycle of a frame.
        send(8'hC3);
        idle(4);
        pulse_reset();
        idle(FL + 4);

        // Reset wins over a simultaneous in_valid.
        in_valid = 1'b1;
        in_data  = 8'hF0;
        pulse_reset();
        in_valid = 1'b0;
        idle(3);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                send(8'($urandom));
                idle($urandom_range(0, FL + 1));
                pulse_reset();
            end else begin
                send(8'($urandom));
                if ($urandom_range(0, 2) != 0) begin
                    idle($urandom_range(0, 12));
                end
            end
        end
        idle(FL + 6);

        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL leftover_expected actual=%0d/%0d required=0/0", q[0].size(), q[1].size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shiftreg_ctrl.md
Name: shiftreg_ctrl

Overview:
Sequencing controller for the team's 8-bit `shiftreg` block (ports clk, in_bit, w_data, w_en, out_bit).
- Accepts parallel words over a valid/ready handshake.
- Loads each word into the shift register, then lets it shift for W cycles.
- Presents the serial stream with valid/last framing.
- Sits between a byte producer and a serial sink; `shiftreg` is instantiated alongside it at the same level.

Parameters:
W, 8, word width; must equal the shiftreg width.
LSB_FIRST, 0, 1 bit-reverses the word before load so bit 0 leaves first.
FILL, 1'b0, constant driven on sr_in_bit.
CNT_W, 16, width of the frame counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  producer has a word
in_data  in  W  word to serialise
in_ready  out  1  controller accepts in_data this cycle
sr_w_en  out  1  to shiftreg w_en (load strobe)
sr_w_data  out  W  to shiftreg w_data
sr_in_bit  out  1  to shiftreg in_bit
sr_out_bit  in  1  from shiftreg out_bit
ser_valid  out  1  ser_bit is a frame bit this cycle
ser_bit  out  1  serial data
ser_last  out  1  final bit of the frame
busy  out  1  state != IDLE
frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Shiftreg contract, fixed:
  - At a posedge with w_en=1: reg <= w_data.
  - At a posedge with w_en=0: reg <= {reg[W-2:0], in_bit}.
  - out_bit = reg[W-1].
- States: IDLE, LOAD, SHIFT, PAR (PAR exists only with the optional feature).
- Handshake: a word is accepted when in_valid && in_ready at a posedge.
  - in_ready=1 in IDLE.
  - in_ready=1 in the final frame-bit cycle (back-to-back).
  - in_ready=0 otherwise.
  - The accepted word is captured into an internal register. in_data need not stay stable after acceptance.
- IDLE:
  - All outputs 0, except sr_in_bit=FILL and sr_w_data=captured word.
  - On accept, go to LOAD.
- LOAD, 1 cycle:
  - sr_w_en=1; sr_w_data = captured word, bit-reversed if LSB_FIRST.
  - Next state SHIFT with cnt=0.
- SHIFT, W cycles, cnt 0..W-1:
  - sr_w_en=0, ser_valid=1, ser_bit=sr_out_bit.
  - ser_last=1 when cnt==W-1 and PAR is absent.
  - After cnt==W-1: go to PAR if present; else LOAD if a word was accepted that cycle; else IDLE.
- Latency: accept edge E0 → LOAD cycle → first ser_valid in the cycle after E1, i.e. 2 cycles after E0.
  - Back-to-back frames have exactly one ser_valid=0 gap cycle (the LOAD).
- frame_cnt increments at the posedge ending the ser_last cycle.
- sr_in_bit=FILL always. Fill bits are never flagged valid.
- Reset at any point, including mid-frame:
  - Next state IDLE; cnt=0; frame_cnt=0; captured word=0.
  - ser_valid, ser_last, sr_w_en, busy all 0 from the cycle after the reset edge.
  - The partial frame is dropped without ser_last.
- Simultaneous rst and in_valid: reset wins; the word is not accepted.
- in_valid with in_ready=0: ignored. The producer must hold the word.

Optional Feature:
SHIFTREG_CTRL_PARITY_EN
- Defined: PAR state follows SHIFT for one cycle.
  - ser_valid=1, ser_bit = even parity (XOR of the captured W bits), ser_last=1.
  - The back-to-back accept moves to this cycle.
  - Frame length is W+1.
- Undefined: no PAR state; the frame is W bits and ser_last is on cnt==W-1.

Decomposition:
- Package shiftreg_ctrl_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, PAR);
  - default W=8;
  - cnt width = $clog2(W).
- No sub-module required; the bit-reverse and parity are inline functions in the package.
- The bench instantiates shiftreg_ctrl plus the existing `shiftreg`.

Test Plan:
1. Reset then idle: rst 2 cycles, in_valid=0 → in_ready=1, busy=0, ser_valid=0, frame_cnt=0.
2. Single word, MSB first: in_data=8'h55 accepted at E0 → ser_valid from E0+2 for 8 cycles, bits 0,1,0,1,0,1,0,1; ser_last on the 8th; frame_cnt=1.
3. LSB_FIRST=1 with 8'h01 → first serial bit 1, then seven 0s; ser_last on the 8th.
4. Back-to-back: in_valid held high with 8'hA5 then 8'h3C → exactly one gap cycle between frames; bits 10100101 then 00111100; frame_cnt=2.
5. Reset mid-frame: rst asserted at the 4th shift cycle → ser_valid=0 next cycle, state IDLE, frame_cnt=0, no ser_last emitted.
6. SHIFTREG_CTRL_PARITY_EN defined: 8'h07 → 9 valid bits, 9th=1, ser_last on the 9th; 8'h03 → 9th=0.
